// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared pipeline definitions for the 5-stage MIPS datapath.
//   hz_state_e      : hazard controller FSM state encoding (RUN=0, MUL=1)
//   REG_ZERO        : architectural register $zero index
//   load_use_match  : load-use compare, shared with the forwarding unit
package hazard_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_RUN = 1'b0,
    ST_MUL = 1'b1
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when a load in EX writes a register the ID instruction reads.
  // Writes to $zero never create a dependency.
  function automatic logic load_use_match(
    input logic       ex_mem_read,
    input logic [4:0] ex_rt,
    input logic [4:0] id_rs,
    input logic [4:0] id_rt,
    input logic       id_uses_rs,
    input logic       id_uses_rt
  );
    return ex_mem_read && (ex_rt != REG_ZERO) &&
           ((id_uses_rs && (id_rs == ex_rt)) ||
            (id_uses_rt && (id_rt == ex_rt)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones instead of wrapping.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (value -> 0)
//   inc   : add one this cycle (ignored once saturated)
//   clear : synchronous clear, has priority over inc
//   value : current count
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (clear) begin
      value_d = '0;
    end else if (inc && (value_q != '1)) begin
      value_d = value_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline control for the 5-stage MIPS datapath.
// Generates PC / IF/ID / ID/EX stall, hold and flush controls for load-use
// hazards, multi-cycle multiplies in EX and taken-branch redirects, and keeps
// saturating stall / redirect performance counters.
//   clk, reset_n            : clock (rising), async active-low reset
//   IDRs, IDRt              : source fields of the IF/ID instruction
//   IDUsesRs, IDUsesRt      : ID instruction actually reads rs / rt
//   EXMemRead, EXRt         : load indication and destination of ID/EX output
//   EXMulStart              : multiply entering EX this cycle
//   EXBranchTaken           : EX resolved a taken branch/jump
//   PCWrite, IFIDWrite      : PC / IF/ID load enables
//   IFIDFlush, IDEXFlush    : zero IF/ID / ID/EX on the next edge
//   IDEXHold                : ID/EX and EX hold their contents
//   PCSrcRedirect           : PC takes the branch target
//   MulBusy                 : controller is in the multiply freeze state
//   StallCycles, FlushCount : saturating performance counters
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       IDRs,
  input  logic [4:0]       IDRt,
  input  logic             IDUsesRs,
  input  logic             IDUsesRt,
  input  logic             EXMemRead,
  input  logic [4:0]       EXRt,
  input  logic             EXMulStart,
  input  logic             EXBranchTaken,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXHold,
  output logic             IDEXFlush,
  output logic             PCSrcRedirect,
  output logic             MulBusy,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  // MUL_LAT is at most 15, so four bits always hold MUL_LAT-1.
  localparam int unsigned MCW = 4;

  hz_state_e        state_q, state_d;
  logic [MCW-1:0]   mcnt_q, mcnt_d;
  logic             lu;
  logic             stall_inc;
  logic             flush_inc;

  assign lu = (state_q == ST_RUN) &&
              load_use_match(EXMemRead, EXRt, IDRs, IDRt, IDUsesRs, IDUsesRt);

  // Outputs are gated by reset_n so they sit at their reset values while
  // reset is held, independent of whatever the pipeline inputs are doing.
  always_comb begin
    state_d       = state_q;
    mcnt_d        = mcnt_q;
    PCWrite       = 1'b1;
    IFIDWrite     = 1'b1;
    IFIDFlush     = 1'b0;
    IDEXHold      = 1'b0;
    IDEXFlush     = 1'b0;
    PCSrcRedirect = 1'b0;
    MulBusy       = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    if (reset_n) begin
      case (state_q)
        ST_RUN: begin
          if (EXBranchTaken) begin
            // The ID instruction is squashed, so any coincident lu is moot.
            PCSrcRedirect = 1'b1;
            IFIDFlush     = 1'b1;
            IDEXFlush     = 1'b1;
            flush_inc     = 1'b1;
          end else if (EXMulStart) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXHold  = 1'b1;
            stall_inc = 1'b1;
            state_d   = ST_MUL;
            mcnt_d    = MCW'(MUL_LAT - 1);
          end else if (lu) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
            stall_inc = 1'b1;
          end
        end
        ST_MUL: begin
          MulBusy   = 1'b1;
          PCWrite   = 1'b0;
          IFIDWrite = 1'b0;
          IDEXHold  = 1'b1;
          stall_inc = 1'b1;
          mcnt_d    = mcnt_q - 1'b1;
          if (mcnt_q == MCW'(1)) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
          mcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .inc   (stall_inc),
    .clear (1'b0),
    .value (StallCycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .inc   (flush_inc),
    .clear (1'b0),
    .value (FlushCount)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed + random bench for hazard_ctrl against a
// cycle-level reference model of the pipeline control rules.
module tb_hazard_ctrl;

  localparam int MUL_LAT = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] IDRs, IDRt, EXRt;
  logic       IDUsesRs, IDUsesRt, EXMemRead, EXMulStart, EXBranchTaken;

  logic        PCWrite, IFIDWrite, IFIDFlush, IDEXHold, IDEXFlush, PCSrcRedirect, MulBusy;
  logic [15:0] StallCycles, FlushCount;
  logic        PCWrite4, IFIDWrite4, IFIDFlush4, IDEXHold4, IDEXFlush4, PCSrcRedirect4, MulBusy4;
  logic [3:0]  StallCycles4, FlushCount4;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int m_mul_left = 0;   // cycles still to spend in the multiply freeze after the start cycle
  int m_stall    = 0;
  int m_flush    = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .IDRs(IDRs), .IDRt(IDRt), .IDUsesRs(IDUsesRs), .IDUsesRt(IDUsesRt),
    .EXMemRead(EXMemRead), .EXRt(EXRt), .EXMulStart(EXMulStart), .EXBranchTaken(EXBranchTaken),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush), .IDEXHold(IDEXHold),
    .IDEXFlush(IDEXFlush), .PCSrcRedirect(PCSrcRedirect), .MulBusy(MulBusy),
    .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .IDRs(IDRs), .IDRt(IDRt), .IDUsesRs(IDUsesRs), .IDUsesRt(IDUsesRt),
    .EXMemRead(EXMemRead), .EXRt(EXRt), .EXMulStart(EXMulStart), .EXBranchTaken(EXBranchTaken),
    .PCWrite(PCWrite4), .IFIDWrite(IFIDWrite4), .IFIDFlush(IFIDFlush4), .IDEXHold(IDEXHold4),
    .IDEXFlush(IDEXFlush4), .PCSrcRedirect(PCSrcRedirect4), .MulBusy(MulBusy4),
    .StallCycles(StallCycles4), .FlushCount(FlushCount4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  function automatic bit model_lu();
    return EXMemRead && (EXRt != 5'd0) &&
           ((IDUsesRs && IDRs == EXRt) || (IDUsesRt && IDRt == EXRt));
  endfunction

  // {PCWrite, IFIDWrite, IFIDFlush, IDEXHold, IDEXFlush, PCSrcRedirect, MulBusy}
  function automatic logic [6:0] model_ctrl();
    if (!reset_n)           return 7'b1100000;
    if (m_mul_left > 0)     return 7'b0001001;
    if (EXBranchTaken)      return 7'b1110110;
    if (EXMulStart)         return 7'b0001000;
    if (model_lu())         return 7'b0000100;
    return 7'b1100000;
  endfunction

  task automatic model_reset();
    m_mul_left = 0;
    m_stall    = 0;
    m_flush    = 0;
  endtask

  task automatic model_clock();
    if (!reset_n) return;
    if (m_mul_left > 0) begin
      m_stall++;
      m_mul_left--;
    end else if (EXBranchTaken) begin
      m_flush++;
    end else if (EXMulStart) begin
      m_stall++;
      m_mul_left = MUL_LAT - 1;
    end else if (model_lu()) begin
      m_stall++;
    end
  endtask

  task automatic idle_inputs();
    IDRs = 5'd0; IDRt = 5'd0; EXRt = 5'd0;
    IDUsesRs = 1'b0; IDUsesRt = 1'b0; EXMemRead = 1'b0;
    EXMulStart = 1'b0; EXBranchTaken = 1'b0;
  endtask

  // Called just after a negedge with inputs already driven: checks the
  // combinational controls, clocks, then checks the counters.
  task automatic cycle(input string tag);
    logic [6:0] exp_c;
    #1;
    exp_c = model_ctrl();
    chk({tag, ".ctrl"},  32'({PCWrite, IFIDWrite, IFIDFlush, IDEXHold, IDEXFlush, PCSrcRedirect, MulBusy}), 32'(exp_c));
    chk({tag, ".ctrl4"}, 32'({PCWrite4, IFIDWrite4, IFIDFlush4, IDEXHold4, IDEXFlush4, PCSrcRedirect4, MulBusy4}), 32'(exp_c));
    chk({tag, ".excl"},  32'((IDEXHold & IDEXFlush) | (~IFIDWrite & IFIDFlush)), 32'(0));
    @(posedge clk);
    model_clock();
    #1;
    chk({tag, ".stall"},  32'(StallCycles),  32'(sat(m_stall, 65535)));
    chk({tag, ".flush"},  32'(FlushCount),   32'(sat(m_flush, 65535)));
    chk({tag, ".stall4"}, 32'(StallCycles4), 32'(sat(m_stall, 15)));
    chk({tag, ".flush4"}, 32'(FlushCount4),  32'(sat(m_flush, 15)));
    @(negedge clk);
  endtask

  initial begin
    int s0;
    int pcw_low;
    int busy_hi;
    idle_inputs();
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset held for three cycles, then idle.
    for (int i = 0; i < 3; i++) cycle("reset");
    chk("reset.counters", 32'({StallCycles, FlushCount}), 32'(0));
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) cycle("idle");

    // Load-use on rs.
    EXMemRead = 1'b1; EXRt = 5'd8; IDRs = 5'd8; IDUsesRs = 1'b1;
    cycle("lu");
    chk("lu.stall_one", 32'(StallCycles), 32'(1));
    idle_inputs();
    cycle("lu.after");
    // Same pattern targeting $zero: no stall.
    EXMemRead = 1'b1; EXRt = 5'd0; IDRs = 5'd0; IDUsesRs = 1'b1;
    cycle("lu.zero");
    chk("lu.zero_nostall", 32'(StallCycles), 32'(1));
    idle_inputs();

    // Multiply: freeze for MUL_LAT cycles, busy for MUL_LAT-1.
    s0 = int'(StallCycles);
    pcw_low = 0; busy_hi = 0;
    EXMulStart = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (!PCWrite && IDEXHold) pcw_low++;
      if (MulBusy) busy_hi++;
      #0;
      cycle("mul");
      EXMulStart = 1'b0;
    end
    chk("mul.freeze_cycles", 32'(pcw_low), 32'(MUL_LAT));
    chk("mul.busy_cycles",   32'(busy_hi), 32'(MUL_LAT - 1));
    chk("mul.stall_delta",   32'(int'(StallCycles) - s0), 32'(MUL_LAT));

    // Branch with coincident load-use: redirect wins, no stall counted.
    s0 = int'(StallCycles);
    EXBranchTaken = 1'b1; EXMemRead = 1'b1; EXRt = 5'd5; IDRt = 5'd5; IDUsesRt = 1'b1;
    cycle("br_lu");
    chk("br_lu.flush", 32'(FlushCount), 32'(1));
    chk("br_lu.stall_same", 32'(StallCycles), 32'(s0));
    idle_inputs();

    // Branch during MUL is ignored; then async reset mid-MUL.
    EXMulStart = 1'b1;
    cycle("mulmask.start");
    EXMulStart = 1'b0; EXBranchTaken = 1'b1;
    cycle("mulmask.br");
    chk("mulmask.flush_same", 32'(FlushCount), 32'(1));
    chk("mulmask.busy", 32'(MulBusy), 32'(1));
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("areset.busy", 32'(MulBusy), 32'(0));
    chk("areset.counters", 32'({StallCycles, FlushCount}), 32'(0));
    @(negedge clk);
    cycle("areset.held");
    idle_inputs();
    reset_n = 1'b1;
    cycle("areset.release");

    // Saturation: 20 consecutive load-use cycles.
    EXMemRead = 1'b1; EXRt = 5'd3; IDRt = 5'd3; IDUsesRt = 1'b1;
    for (int i = 0; i < 20; i++) cycle("sat");
    chk("sat.w4_hold15", 32'(StallCycles4), 32'(15));
    chk("sat.w16_count20", 32'(StallCycles), 32'(20));
    idle_inputs();

    // Random traffic, including back-to-back multiplies.
    for (int i = 0; i < 400; i++) begin
      IDRs          = 5'($urandom_range(0, 3));
      IDRt          = 5'($urandom_range(0, 3));
      EXRt          = 5'($urandom_range(0, 3));
      IDUsesRs      = 1'($urandom_range(0, 1));
      IDUsesRt      = 1'($urandom_range(0, 1));
      EXMemRead     = 1'($urandom_range(0, 1));
      EXMulStart    = ($urandom_range(0, 5) == 0);
      EXBranchTaken = ($urandom_range(0, 6) == 0);
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
